shifter_arbiter: RTL and testbench
==================================

SHIFTER_ARBITER -- requirements
Module: shifter_arbiter

Interface
REQ-001 Parameter: EXEC_CYCLES, default 1, number of settle cycles given to the shared Shifter before capture (legal 1..15).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  2  per-requester operation request; bit i = requester i.
REQ-005 req_ready  output  2  per-requester accept; one-hot or zero.
REQ-006 req_a0, req_a1  input  32 each  operand to shift, requester 0/1.
REQ-007 req_b0, req_b1  input  32 each  shift amount, requester 0/1; only bits [4:0] significant.
REQ-008 req_ctl0  input  2  bit i: 1 = logical, 0 = arithmetic, requester i.
REQ-009 req_ctl1  input  2  bit i: 1 = right, 0 = left, requester i.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 res_out  output  32  shifted result.
REQ-013 res_id  output  1  index of requester that owns res_out.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, EXEC, DONE.
REQ-016 IDLE: grant = sole valid requester; both valid -> requester equal to priority pointer; none -> no grant.
REQ-017 req_ready[i] SHALL be high only in IDLE and only for the granted requester; combinational from req_valid and pointer.
REQ-018 Accept = req_valid[i] & req_ready[i]; on accept latch A, B[4:0], ctl0, ctl1, id into operand registers, load settle counter with EXEC_CYCLES-1, go to EXEC.
REQ-019 Priority pointer SHALL become the non-granted index on every accept; unchanged otherwise.
REQ-020 Shifter inputs SHALL come only from operand registers; requester inputs never drive it directly.
REQ-021 EXEC: counter decrements each cycle; at count 0 capture Shifter output into res_out, set res_valid, go to DONE.
REQ-022 Latency: accept edge N -> res_valid high after edge N+EXEC_CYCLES.
REQ-023 DONE: res_out, res_id SHALL be held stable while res_valid & !res_ready.
REQ-024 DONE with res_ready high: clear res_valid, go to IDLE; no new accept in that same cycle (one bubble).
REQ-025 Peak throughput SHALL be one operation per EXEC_CYCLES+2 cycles.
REQ-026 req_valid changes outside IDLE SHALL have no effect; requests are not queued.
REQ-027 Shift semantics (ctl0/ctl1 combinations, B[31:5] ignored) SHALL be exactly those of Shifter; arbiter adds no transformation.

Reset
REQ-028 Reset SHALL force IDLE, pointer=0, res_valid=0, res_out=0, res_id=0, busy=0, counter=0, operand registers=0.
REQ-029 Reset asserted in EXEC or DONE SHALL discard the in-flight operation with no result emitted.
REQ-030 req_ready SHALL be 0 in any cycle reset is high.

Structure
REQ-031 Shared package SHALL hold state encoding (IDLE/EXEC/DONE), ctl encodings (LOGICAL=1, RIGHT=1) and width constant 32.
REQ-032 Exactly one Shifter instance SHALL be the sole sub-module; all sequencing logic lives in shifter_arbiter.

Verification
REQ-033 Req0 only: A=0x80000000, B=4, ctl0=0, ctl1=1 -> res_out=0xF8000000, res_id=0, res_valid after EXEC_CYCLES+1 edges.
REQ-034 Req1 only: A=0x80000000, B=0x24, ctl0=1, ctl1=1 -> res_out=0x08000000 (B[31:5] ignored), res_id=1.
REQ-035 Both valid continuously, res_ready=1: grants alternate 0,1,0,1 starting at 0 after reset; one accept per EXEC_CYCLES+2 cycles.
REQ-036 Req0 A=0x00000001, B=31, ctl0=1, ctl1=0, res_ready=0 for 5 cycles -> res_out=0x80000000 held stable, req_ready=0 throughout, then IDLE.
REQ-037 Reset asserted in EXEC -> next cycle IDLE, res_valid=0, pointer=0, no result emitted.

Source files
------------

// File: rtl/shifter_arbiter_pkg.sv
// Shared definitions for the two-requester shifter arbiter.
// Holds the FSM state encoding, the ctl bit encodings, datapath widths and
// the captured-operation record used by the sequencer.
package shifter_arbiter_pkg;

  localparam int unsigned DataWidth  = 32;
  localparam int unsigned ShamtWidth = 5;
  localparam int unsigned NumReq     = 2;
  localparam int unsigned CntWidth   = 4;

  // ctl0 selects logical (1) vs arithmetic (0); ctl1 selects right (1) vs left (0).
  localparam logic CtlLogical = 1'b1;
  localparam logic CtlRight   = 1'b1;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StDone = 2'd2
  } state_e;

  // Operation as latched from the granted requester.
  typedef struct packed {
    logic [DataWidth-1:0]  a;
    logic [ShamtWidth-1:0] b;
    logic                  logical;
    logic                  right;
    logic                  id;
  } op_t;

  function automatic logic [NumReq-1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/shifter_arbiter_shifter.sv
// Combinational 32-bit barrel shifter shared by both requesters.
// Ports:
//   a       operand to shift
//   shamt   shift amount (0..31)
//   logical 1 = logical, 0 = arithmetic (only matters for right shifts)
//   right   1 = shift right, 0 = shift left
//   result  shifted value
module shifter_arbiter_shifter
  import shifter_arbiter_pkg::*;
(
  input  logic [DataWidth-1:0]  a,
  input  logic [ShamtWidth-1:0] shamt,
  input  logic                  logical,
  input  logic                  right,
  output logic [DataWidth-1:0]  result
);

  always_comb begin
    result = '0;
    if (right == CtlRight) begin
      if (logical == CtlLogical) begin
        result = a >> shamt;
      end else begin
        result = DataWidth'($signed(a) >>> shamt);
      end
    end else begin
      // Left shifts fill with zeros regardless of logical/arithmetic.
      result = a << shamt;
    end
  end

endmodule

// File: rtl/shifter_arbiter.sv
// Two-requester arbiter in front of a single shared shifter.
// One operation is in flight at a time: IDLE grants and latches operands,
// EXEC lets the shifter settle for EXEC_CYCLES cycles, DONE holds the result
// until the consumer takes it. Ties are broken by a pointer that flips to the
// loser on every accept.
// Ports:
//   clk, reset           clock and synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready is one-hot or zero)
//   req_a0/a1, req_b0/b1 operand and shift amount per requester (b[4:0] used)
//   req_ctl0, req_ctl1   bit i: logical/arith and right/left for requester i
//   res_valid/res_ready  result handshake
//   res_out, res_id      result value and owning requester
//   busy                 high whenever the FSM is not idle
module shifter_arbiter
  import shifter_arbiter_pkg::*;
#(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NumReq-1:0]    req_valid,
  output logic [NumReq-1:0]    req_ready,
  input  logic [DataWidth-1:0] req_a0,
  input  logic [DataWidth-1:0] req_a1,
  input  logic [DataWidth-1:0] req_b0,
  input  logic [DataWidth-1:0] req_b1,
  input  logic [NumReq-1:0]    req_ctl0,
  input  logic [NumReq-1:0]    req_ctl1,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DataWidth-1:0] res_out,
  output logic                 res_id,
  output logic                 busy
);

  localparam logic [CntWidth-1:0] ExecLoad = CntWidth'(EXEC_CYCLES - 1);

  state_e               state_q;
  logic                 ptr_q;
  logic [CntWidth-1:0]  cnt_q;
  op_t                  op_q;

  logic                 grant_any;
  logic                 grant_id;
  logic                 accept;
  op_t                  sel_op;
  logic [DataWidth-1:0] shift_result;

  // Shift amount bits above [4:0] are architecturally ignored.
  logic unused_b_hi;
  assign unused_b_hi = ^{req_b0[DataWidth-1:ShamtWidth], req_b1[DataWidth-1:ShamtWidth]};

  always_comb begin
    grant_any = 1'b0;
    grant_id  = 1'b0;
    case (req_valid)
      2'b01: begin
        grant_any = 1'b1;
        grant_id  = 1'b0;
      end
      2'b10: begin
        grant_any = 1'b1;
        grant_id  = 1'b1;
      end
      2'b11: begin
        grant_any = 1'b1;
        grant_id  = ptr_q;
      end
      2'b00: begin
        grant_any = 1'b0;
        grant_id  = 1'b0;
      end
    endcase
  end

  assign req_ready = (state_q == StIdle && !reset && grant_any) ? id_to_onehot(grant_id) : '0;
  assign accept    = |(req_valid & req_ready);
  assign busy      = (state_q != StIdle);

  always_comb begin
    sel_op.a       = grant_id ? req_a1 : req_a0;
    sel_op.b       = grant_id ? req_b1[ShamtWidth-1:0] : req_b0[ShamtWidth-1:0];
    sel_op.logical = req_ctl0[grant_id];
    sel_op.right   = req_ctl1[grant_id];
    sel_op.id      = grant_id;
  end

  // The shifter only ever sees latched operands, so requester inputs may
  // change freely once an operation has been accepted.
  shifter_arbiter_shifter u_shifter (
    .a       (op_q.a),
    .shamt   (op_q.b),
    .logical (op_q.logical),
    .right   (op_q.right),
    .result  (shift_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      ptr_q     <= 1'b0;
      cnt_q     <= '0;
      op_q      <= '0;
      res_valid <= 1'b0;
      res_out   <= '0;
      res_id    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            op_q    <= sel_op;
            cnt_q   <= ExecLoad;
            ptr_q   <= ~grant_id;
            state_q <= StExec;
          end
        end
        StExec: begin
          if (cnt_q == '0) begin
            res_out   <= shift_result;
            res_id    <= op_q.id;
            res_valid <= 1'b1;
            state_q   <= StDone;
          end else begin
            cnt_q <= cnt_q - CntWidth'(1);
          end
        end
        StDone: begin
          // Returning to idle costs one bubble before the next grant.
          if (res_ready) begin
            res_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_shifter_arbiter.sv
module tb_shifter_arbiter;

  localparam int unsigned EXEC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_a0, req_a1, req_b0, req_b1;
  logic [1:0]  req_ctl0, req_ctl1;
  logic        res_valid, res_ready;
  logic [31:0] res_out;
  logic        res_id, busy;

  int checks = 0;
  int errors = 0;
  logic model_ptr;

  always #5 clk = ~clk;

  shifter_arbiter #(.EXEC_CYCLES(EXEC)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a0    (req_a0),
    .req_a1    (req_a1),
    .req_b0    (req_b0),
    .req_b1    (req_b1),
    .req_ctl0  (req_ctl0),
    .req_ctl1  (req_ctl1),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_out   (res_out),
    .res_id    (res_id),
    .busy      (busy)
  );

  // Reference shift built from multiply/divide by powers of two.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic logical, input logic right);
    longint unsigned p, av, r;
    int unsigned amt;
    amt = b % 32;
    p = 1;
    for (int i = 0; i < int'(amt); i++) p = p * 2;
    av = {32'd0, a};
    if (!right) r = (av * p) % 64'h1_0000_0000;
    else if (logical || av < 64'h8000_0000) r = av / p;
    else r = 64'hFFFF_FFFF - ((64'hFFFF_FFFF - av) / p);
    return r[31:0];
  endfunction

  function automatic logic [31:0] exp_for(input logic g);
    if (g) return ref_shift(req_a1, req_b1, req_ctl0[1], req_ctl1[1]);
    return ref_shift(req_a0, req_b0, req_ctl0[0], req_ctl1[0]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rand_ops();
    req_a0   = $urandom;
    req_a1   = $urandom;
    req_b0   = $urandom;
    req_b1   = $urandom;
    req_ctl0 = 2'($urandom_range(0, 3));
    req_ctl1 = 2'($urandom_range(0, 3));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = 2'b00;
    res_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    model_ptr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req_valid = 2'b11;
    res_ready = 1'b1;
    rand_ops();
    settle();
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 00", req_ready);
    end
    tick();
    tick();
    checks++;
    if (res_valid !== 1'b0 || res_out !== 32'h0 || res_id !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got valid=%b out=%h id=%b busy=%b expected 0/0/0/0",
               res_valid, res_out, res_id, busy);
    end
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL reset_ready_held: got %b expected 00", req_ready);
    end
    reset = 1'b0;
    model_ptr = 1'b0;
    settle();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL reset_ptr: got %b expected 01", req_ready);
    end
    req_valid = 2'b00;
    res_ready = 1'b0;
    tick();
  endtask

  task automatic test_req0_only();
    int n;
    req_a0 = 32'h8000_0000;
    req_b0 = 32'd4;
    req_ctl0[0] = 1'b0;
    req_ctl1[0] = 1'b1;
    req_valid = 2'b01;
    res_ready = 1'b0;
    settle();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL req0_ready: got %b expected 01", req_ready);
    end
    tick();
    model_ptr = 1'b1;
    req_valid = 2'b00;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != EXEC) begin
      errors++;
      $display("FAIL req0_latency: got %0d expected %0d", n, EXEC);
    end
    checks++;
    if (res_out !== 32'hF800_0000 || res_id !== 1'b0) begin
      errors++;
      $display("FAIL req0_result: got %h id %b expected f8000000 id 0", res_out, res_id);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL req0_release: got valid=%b busy=%b expected 0/0", res_valid, busy);
    end
  endtask

  task automatic test_req1_only();
    int n;
    req_a1 = 32'h8000_0000;
    req_b1 = 32'h24;
    req_ctl0[1] = 1'b1;
    req_ctl1[1] = 1'b1;
    req_valid = 2'b10;
    settle();
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("FAIL req1_ready: got %b expected 10", req_ready);
    end
    tick();
    model_ptr = 1'b0;
    req_valid = 2'b00;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != EXEC || res_out !== 32'h0800_0000 || res_id !== 1'b1) begin
      errors++;
      $display("FAIL req1_result: got lat=%0d %h id %b expected lat=%0d 08000000 id 1",
               n, res_out, res_id, EXEC);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_alternate();
    int period;
    int phase;
    logic g;
    logic [31:0] exp_res;
    logic exp_id;
    logic [1:0] exp_ready;
    do_reset();
    period = EXEC + 2;
    g = 1'b0;
    exp_res = '0;
    exp_id = 1'b0;
    res_ready = 1'b1;
    req_valid = 2'b11;
    for (int c = 0; c < 4 * period; c++) begin
      rand_ops();
      settle();
      phase = c % period;
      exp_ready = (phase == 0) ? (g ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL alt_ready c=%0d: got %b expected %b", c, req_ready, exp_ready);
      end
      checks++;
      if (res_valid !== (phase == period - 1) || busy !== (phase != 0)) begin
        errors++;
        $display("FAIL alt_state c=%0d: got valid=%b busy=%b expected %b/%b", c, res_valid,
                 busy, (phase == period - 1), (phase != 0));
      end
      if (phase == period - 1) begin
        checks++;
        if (res_out !== exp_res || res_id !== exp_id) begin
          errors++;
          $display("FAIL alt_result c=%0d: got %h id %b expected %h id %b", c, res_out, res_id,
                   exp_res, exp_id);
        end
      end
      if (phase == 0) begin
        exp_res = exp_for(g);
        exp_id = g;
        g = ~g;
      end
      tick();
    end
    req_valid = 2'b00;
    res_ready = 1'b0;
    model_ptr = g;
  endtask

  task automatic test_hold();
    int n;
    req_a0 = 32'h1;
    req_b0 = 32'd31;
    req_ctl0[0] = 1'b1;
    req_ctl1[0] = 1'b0;
    req_valid = 2'b01;
    res_ready = 1'b0;
    settle();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL hold_ready: got %b expected 01", req_ready);
    end
    tick();
    model_ptr = 1'b1;
    req_valid = 2'b00;
    n = 0;
    while (res_valid !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n != EXEC) begin
      errors++;
      $display("FAIL hold_latency: got %0d expected %0d", n, EXEC);
    end
    for (int s = 0; s < 5; s++) begin
      req_valid = 2'b11;
      rand_ops();
      settle();
      checks++;
      if (res_valid !== 1'b1 || res_out !== 32'h8000_0000 || res_id !== 1'b0 ||
          req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable s=%0d: got v=%b %h id %b rdy=%b busy=%b expected 1 80000000 0 00 1",
                 s, res_valid, res_out, res_id, req_ready, busy);
      end
      tick();
    end
    res_ready = 1'b1;
    settle();
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL hold_done_ready: got %b expected 00", req_ready);
    end
    tick();
    res_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || req_ready !== 2'b10) begin
      errors++;
      $display("FAIL hold_idle: got busy=%b valid=%b rdy=%b expected 0 0 10", busy, res_valid,
               req_ready);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_reset_exec();
    req_a0 = 32'hDEAD_BEEF;
    req_b0 = 32'd3;
    req_valid = 2'b01;
    settle();
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rexec_ready: got %b expected 01", req_ready);
    end
    tick();
    reset = 1'b1;
    req_valid = 2'b11;
    settle();
    checks++;
    if (req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rexec_ready_in_reset: got %b expected 00", req_ready);
    end
    tick();
    reset = 1'b0;
    model_ptr = 1'b0;
    settle();
    checks++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || res_out !== 32'h0 || res_id !== 1'b0 ||
        req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rexec_state: got busy=%b v=%b %h id %b rdy=%b expected 0 0 0 0 01",
               busy, res_valid, res_out, res_id, req_ready);
    end
    req_valid = 2'b00;
    res_ready = 1'b1;
    for (int i = 0; i < int'(EXEC) + 3; i++) begin
      tick();
      checks++;
      if (res_valid !== 1'b0) begin
        errors++;
        $display("FAIL rexec_no_result i=%0d: got %b expected 0", i, res_valid);
      end
    end
    res_ready = 1'b0;
  endtask

  task automatic test_random();
    int n;
    int gap;
    int stall;
    logic g;
    logic [1:0] v;
    logic [31:0] exp_res;
    for (int op = 0; op < 40; op++) begin
      gap = $urandom_range(0, 2);
      for (int i = 0; i < gap; i++) begin
        req_valid = 2'b00;
        rand_ops();
        settle();
        checks++;
        if (req_ready !== 2'b00) begin
          errors++;
          $display("FAIL rnd_idle_ready op=%0d: got %b expected 00", op, req_ready);
        end
        tick();
      end
      rand_ops();
      v = 2'($urandom_range(1, 3));
      req_valid = v;
      res_ready = 1'b0;
      g = (v == 2'b01) ? 1'b0 : (v == 2'b10) ? 1'b1 : model_ptr;
      settle();
      checks++;
      if (req_ready !== (g ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rnd_grant op=%0d: got %b expected %b", op, req_ready,
                 (g ? 2'b10 : 2'b01));
      end
      exp_res = exp_for(g);
      tick();
      model_ptr = ~g;
      n = 0;
      while (res_valid !== 1'b1 && n < 40) begin
        req_valid = 2'($urandom_range(0, 3));
        rand_ops();
        settle();
        checks++;
        if (req_ready !== 2'b00) begin
          errors++;
          $display("FAIL rnd_exec_ready op=%0d: got %b expected 00", op, req_ready);
        end
        tick();
        n++;
      end
      checks++;
      if (n != EXEC || res_out !== exp_res || res_id !== g) begin
        errors++;
        $display("FAIL rnd_result op=%0d: got lat=%0d %h id %b expected lat=%0d %h id %b", op,
                 n, res_out, res_id, EXEC, exp_res, g);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        req_valid = 2'($urandom_range(0, 3));
        rand_ops();
        tick();
        checks++;
        if (res_valid !== 1'b1 || res_out !== exp_res || res_id !== g) begin
          errors++;
          $display("FAIL rnd_stall op=%0d: got v=%b %h id %b expected 1 %h id %b", op,
                   res_valid, res_out, res_id, exp_res, g);
        end
      end
      req_valid = 2'b00;
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
      checks++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
        errors++;
        $display("FAIL rnd_release op=%0d: got busy=%b valid=%b expected 0 0", op, busy,
                 res_valid);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req_valid = 2'b00;
    res_ready = 1'b0;
    req_a0 = '0;
    req_a1 = '0;
    req_b0 = '0;
    req_b1 = '0;
    req_ctl0 = '0;
    req_ctl1 = '0;
    model_ptr = 1'b0;
    tick();
    test_reset();
    test_req0_only();
    test_req1_only();
    test_alternate();
    test_hold();
    test_reset_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
